// File: rtl/xf100_ifu_fetch_if.sv
// Bundle of fetch-unit signals: ICB fetch command/response, decode handoff,
// redirect and halt handshake. "master" is the fetch unit, "slave" its environment.
`ifndef XF100_XLEN
`define XF100_XLEN 32
`endif
`ifndef XF100_INSTR_SIZE
`define XF100_INSTR_SIZE 32
`endif

interface xf100_ifu_fetch_if;
    logic                          ifu_o_icb_cmd_valid;
    logic                          ifu_i_icb_cmd_ready;
    logic [`XF100_XLEN-1:0]        ifu_o_icb_cmd_addr;
    logic                          ifu_i_icb_rsp_valid;
    logic                          ifu_o_icb_rsp_ready;
    logic [`XF100_INSTR_SIZE-1:0]  ifu_i_icb_rsp_rdata;
    logic                          ifu_i_icb_rsp_err;
    logic                          ifu_o_instr_valid;
    logic                          ifu_i_instr_ready;
    logic [`XF100_INSTR_SIZE-1:0]  ifu_o_instr;
    logic [`XF100_XLEN-1:0]        ifu_o_pc;
    logic                          ifu_o_instr_err;
    logic                          ifu_i_redirect;
    logic [`XF100_XLEN-1:0]        ifu_i_redirect_pc;
    logic                          ifu_i_halt_req;
    logic                          ifu_o_halt_ack;

    modport master (
        output ifu_o_icb_cmd_valid, ifu_o_icb_cmd_addr, ifu_o_icb_rsp_ready,
               ifu_o_instr_valid, ifu_o_instr, ifu_o_pc, ifu_o_instr_err, ifu_o_halt_ack,
        input  ifu_i_icb_cmd_ready, ifu_i_icb_rsp_valid, ifu_i_icb_rsp_rdata, ifu_i_icb_rsp_err,
               ifu_i_instr_ready, ifu_i_redirect, ifu_i_redirect_pc, ifu_i_halt_req
    );

    modport slave (
        input  ifu_o_icb_cmd_valid, ifu_o_icb_cmd_addr, ifu_o_icb_rsp_ready,
               ifu_o_instr_valid, ifu_o_instr, ifu_o_pc, ifu_o_instr_err, ifu_o_halt_ack,
        output ifu_i_icb_cmd_ready, ifu_i_icb_rsp_valid, ifu_i_icb_rsp_rdata, ifu_i_icb_rsp_err,
               ifu_i_instr_ready, ifu_i_redirect, ifu_i_redirect_pc, ifu_i_halt_req
    );
endinterface

// File: rtl/xf100_ifu_fetch.sv
// Instruction fetch unit: credit-limited ICB fetch (2 in flight + buffered),
// 2-entry instruction FIFO to decode, redirect flush with stale-response drop, halt.
`ifndef XF100_XLEN
`define XF100_XLEN 32
`endif
`ifndef XF100_INSTR_SIZE
`define XF100_INSTR_SIZE 32
`endif

module xf100_ifu_fetch #(
    parameter logic [`XF100_XLEN-1:0] IFU_RESET_PC = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst_n,
    xf100_ifu_fetch_if.master   ifu
);
    localparam int XLEN  = `XF100_XLEN;
    localparam int ILEN  = `XF100_INSTR_SIZE;
    localparam logic [XLEN-1:0] RESET_PC = {IFU_RESET_PC[XLEN-1:2], 2'b00};

    typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_HALT} state_t;

    state_t            state_reg, state_next;
    logic [XLEN-1:0]   fetch_pc_reg, fetch_pc_next;
    logic [XLEN-1:0]   rsp_pc_reg, rsp_pc_next;
    logic [1:0]        outst_reg, outst_next;
    logic [1:0]        drop_reg, drop_next;
    logic [1:0]        fifo_cnt_reg, fifo_cnt_next;
    logic              wr_ptr_reg, wr_ptr_next;
    logic              rd_ptr_reg, rd_ptr_next;
    logic [ILEN-1:0]   fifo_instr_reg [0:1];
    logic [XLEN-1:0]   fifo_pc_reg    [0:1];
    logic              fifo_err_reg   [0:1];

    logic credit_ok, cmd_valid, cmd_hs, rsp_hs, push, pop, fifo_nempty, instr_valid;
    logic [1:0] outst_after_rsp;
    logic [XLEN-1:0] redirect_base;
    logic [1:0] unused_redirect_lsb;

    assign unused_redirect_lsb = ifu.ifu_i_redirect_pc[1:0];
    assign redirect_base = {ifu.ifu_i_redirect_pc[XLEN-1:2], 2'b00};

    // Credit counts both in-flight requests and buffered instructions, so a
    // response can always be accepted without back-pressure.
    assign credit_ok   = ({1'b0, outst_reg} + {1'b0, fifo_cnt_reg}) < 3'd2;
    assign cmd_valid   = (state_reg == ST_RUN) & ~ifu.ifu_i_redirect & credit_ok;
    assign cmd_hs      = cmd_valid & ifu.ifu_i_icb_cmd_ready;
    assign rsp_hs      = ifu.ifu_i_icb_rsp_valid;
    assign push        = rsp_hs & (drop_reg == 2'd0) & ~ifu.ifu_i_redirect;
    assign fifo_nempty = (fifo_cnt_reg != 2'd0);
    assign instr_valid = fifo_nempty & ~ifu.ifu_i_redirect;
    assign pop         = instr_valid & ifu.ifu_i_instr_ready;
    assign outst_after_rsp = outst_reg - {1'b0, rsp_hs};

    always_comb begin
        state_next    = state_reg;
        fetch_pc_next = fetch_pc_reg;
        rsp_pc_next   = rsp_pc_reg;
        outst_next    = outst_reg;
        drop_next     = drop_reg;
        fifo_cnt_next = fifo_cnt_reg;
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        if (ifu.ifu_i_redirect) begin
            // Everything still in flight belongs to the old stream and is discarded.
            if (state_reg == ST_BOOT) state_next = ST_RUN;
            fetch_pc_next = redirect_base;
            rsp_pc_next   = redirect_base;
            outst_next    = outst_after_rsp;
            drop_next     = outst_after_rsp;
            fifo_cnt_next = 2'd0;
            wr_ptr_next   = 1'b0;
            rd_ptr_next   = 1'b0;
        end else begin
            unique case (state_reg)
                ST_BOOT: state_next = ST_RUN;
                ST_RUN:  if (ifu.ifu_i_halt_req)  state_next = ST_HALT;
                ST_HALT: if (!ifu.ifu_i_halt_req) state_next = ST_RUN;
                default: state_next = ST_BOOT;
            endcase
            if (cmd_hs) fetch_pc_next = fetch_pc_reg + 32'd4;
            if (push)   rsp_pc_next   = rsp_pc_reg + 32'd4;
            outst_next = outst_after_rsp + {1'b0, cmd_hs};
            if (rsp_hs && (drop_reg != 2'd0)) drop_next = drop_reg - 2'd1;
            fifo_cnt_next = fifo_cnt_reg + {1'b0, push} - {1'b0, pop};
            wr_ptr_next   = wr_ptr_reg ^ push;
            rd_ptr_next   = rd_ptr_reg ^ pop;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_BOOT;
            fetch_pc_reg <= RESET_PC;
            rsp_pc_reg   <= RESET_PC;
            outst_reg    <= 2'd0;
            drop_reg     <= 2'd0;
            fifo_cnt_reg <= 2'd0;
            wr_ptr_reg   <= 1'b0;
            rd_ptr_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            fetch_pc_reg <= fetch_pc_next;
            rsp_pc_reg   <= rsp_pc_next;
            outst_reg    <= outst_next;
            drop_reg     <= drop_next;
            fifo_cnt_reg <= fifo_cnt_next;
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
        end
    end

    // Storage needs no reset: the count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_instr_reg[wr_ptr_reg] <= ifu.ifu_i_icb_rsp_rdata;
            fifo_pc_reg[wr_ptr_reg]    <= rsp_pc_reg;
            fifo_err_reg[wr_ptr_reg]   <= ifu.ifu_i_icb_rsp_err;
        end
    end

    assign ifu.ifu_o_icb_cmd_valid = cmd_valid;
    assign ifu.ifu_o_icb_cmd_addr  = fetch_pc_reg;
    assign ifu.ifu_o_icb_rsp_ready = 1'b1;
    assign ifu.ifu_o_instr_valid   = instr_valid;
    assign ifu.ifu_o_instr         = fifo_nempty ? fifo_instr_reg[rd_ptr_reg] : '0;
    assign ifu.ifu_o_pc            = fifo_nempty ? fifo_pc_reg[rd_ptr_reg]    : '0;
    assign ifu.ifu_o_instr_err     = fifo_nempty ? fifo_err_reg[rd_ptr_reg]   : 1'b0;
    assign ifu.ifu_o_halt_ack      = (state_reg == ST_HALT) & (outst_reg == 2'd0);
endmodule

// File: tb/tb_xf100_ifu_fetch.sv
// Bench for xf100_ifu_fetch: transaction-queue reference model checked every cycle,
// an ICB memory responder, and directed scenarios with literal expectations.
module tb_xf100_ifu_fetch;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    xf100_ifu_fetch_if bus ();
    xf100_ifu_fetch dut (.clk(clk), .rst_n(rst_n), .ifu(bus));

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int rel_cyc = 0;

    bit rsp_en = 1'b1;
    logic [31:0] err_addr = 32'h0000_0F00;

    typedef struct {logic [31:0] instr; logic [31:0] pc; logic err;} ent_t;

    function automatic logic [31:0] mem_word(logic [31:0] a);
        return 32'h0050_0093 + (a << 10);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model: queues of transactions ----------------
    int          m_mode = 0;             // 0 boot, 1 run, 2 halt
    logic [31:0] m_fetch_pc = 32'h0;
    logic [31:0] m_rsp_pc = 32'h0;
    bit          m_flight[$];            // one entry per request in flight, 1 = result wanted
    ent_t        m_out[$];               // instructions waiting for decode

    function automatic bit exp_cmd_valid();
        return (m_mode == 1) && !bus.ifu_i_redirect && ((m_flight.size() + m_out.size()) < 2);
    endfunction
    function automatic bit exp_instr_valid();
        return (m_out.size() > 0) && !bus.ifu_i_redirect;
    endfunction

    task automatic model_step();
        bit cmd_fire, rsp_fire, pop_fire, wanted;
        cmd_fire = exp_cmd_valid() && bus.ifu_i_icb_cmd_ready;
        rsp_fire = bus.ifu_i_icb_rsp_valid;
        pop_fire = exp_instr_valid() && bus.ifu_i_instr_ready;
        wanted = 1'b0;
        if (rsp_fire) begin
            check("rsp_has_request", 32'(m_flight.size() > 0), 32'd1);
            if (m_flight.size() > 0) wanted = m_flight.pop_front();
        end
        if (bus.ifu_i_redirect) begin
            m_out.delete();
            foreach (m_flight[i]) m_flight[i] = 1'b0;
            m_fetch_pc = bus.ifu_i_redirect_pc & ~32'd3;
            m_rsp_pc   = m_fetch_pc;
            if (m_mode == 0) m_mode = 1;
        end else begin
            if (pop_fire) void'(m_out.pop_front());
            if (rsp_fire && wanted) begin
                m_out.push_back('{bus.ifu_i_icb_rsp_rdata, m_rsp_pc, bus.ifu_i_icb_rsp_err});
                m_rsp_pc += 32'd4;
            end
            if (cmd_fire) begin
                m_flight.push_back(1'b1);
                m_fetch_pc += 32'd4;
            end
            if (m_mode == 0) m_mode = 1;
            else if (m_mode == 1 && bus.ifu_i_halt_req) m_mode = 2;
            else if (m_mode == 2 && !bus.ifu_i_halt_req) m_mode = 1;
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_mode = 0; m_fetch_pc = 32'h0; m_rsp_pc = 32'h0;
            m_flight.delete(); m_out.delete();
        end else begin
            model_step();
        end
    end

    // ---------------- ICB memory responder (one cycle latency) ----------------
    logic [31:0] rq[$];
    bit          r_cmd_fire = 1'b0;
    bit          r_rsp_fire = 1'b0;
    logic [31:0] r_cmd_addr = 32'h0;

    initial forever begin
        @(posedge clk);
        if (!rst_n) rq.delete();
        else begin
            if (r_rsp_fire) void'(rq.pop_front());
            if (r_cmd_fire) rq.push_back(r_cmd_addr);
        end
    end

    initial forever begin
        @(negedge clk);
        #1;
        if (rst_n && rsp_en && rq.size() > 0) begin
            bus.ifu_i_icb_rsp_valid = 1'b1;
            bus.ifu_i_icb_rsp_rdata = mem_word(rq[0]);
            bus.ifu_i_icb_rsp_err   = (rq[0] == err_addr);
        end else begin
            bus.ifu_i_icb_rsp_valid = 1'b0;
            bus.ifu_i_icb_rsp_rdata = 32'h0;
            bus.ifu_i_icb_rsp_err   = 1'b0;
        end
    end

    // ---------------- per-cycle compare and transaction logs ----------------
    logic [31:0] cmd_log[$];
    int          cmd_cyc[$];
    ent_t        dlv_log[$];

    initial forever begin
        @(negedge clk);
        #2;
        cyc++;
        check("cmd_valid", 32'(bus.ifu_o_icb_cmd_valid), 32'(exp_cmd_valid()));
        check("cmd_addr", bus.ifu_o_icb_cmd_addr, m_fetch_pc);
        check("rsp_ready", 32'(bus.ifu_o_icb_rsp_ready), 32'd1);
        check("instr_valid", 32'(bus.ifu_o_instr_valid), 32'(exp_instr_valid()));
        check("halt_ack", 32'(bus.ifu_o_halt_ack), 32'((m_mode == 2) && (m_flight.size() == 0)));
        if (exp_instr_valid()) begin
            check("instr", bus.ifu_o_instr, m_out[0].instr);
            check("pc", bus.ifu_o_pc, m_out[0].pc);
            check("instr_err", 32'(bus.ifu_o_instr_err), 32'(m_out[0].err));
        end else if (!rst_n) begin
            check("rst_instr", bus.ifu_o_instr, 32'h0);
            check("rst_pc", bus.ifu_o_pc, 32'h0);
            check("rst_instr_err", 32'(bus.ifu_o_instr_err), 32'd0);
        end
        r_cmd_fire = bus.ifu_o_icb_cmd_valid && bus.ifu_i_icb_cmd_ready;
        r_cmd_addr = bus.ifu_o_icb_cmd_addr;
        r_rsp_fire = bus.ifu_i_icb_rsp_valid;
        if (r_cmd_fire) begin
            cmd_log.push_back(bus.ifu_o_icb_cmd_addr);
            cmd_cyc.push_back(cyc);
            $display("cycle %0d: cmd addr=%h", cyc, bus.ifu_o_icb_cmd_addr);
        end
        if (bus.ifu_o_instr_valid && bus.ifu_i_instr_ready) begin
            dlv_log.push_back('{bus.ifu_o_instr, bus.ifu_o_pc, bus.ifu_o_instr_err});
            $display("cycle %0d: instr pc=%h instr=%h err=%0d", cyc, bus.ifu_o_pc,
                     bus.ifu_o_instr, bus.ifu_o_instr_err);
        end
    end

    // ---------------- literal expectation helpers ----------------
    task automatic chk_cmd(string name, int idx, logic [31:0] exp);
        if (idx >= cmd_log.size()) begin
            n_checks++; n_fail++;
            $display("FAIL %s: cmd #%0d never issued, expected addr %h", name, idx, exp);
        end else check(name, cmd_log[idx], exp);
    endtask

    task automatic chk_dlv(string name, int idx, logic [31:0] exp_pc, logic [31:0] exp_instr, logic exp_err);
        if (idx >= dlv_log.size()) begin
            n_checks++; n_fail++;
            $display("FAIL %s: instr #%0d never delivered, expected pc %h", name, idx, exp_pc);
        end else begin
            check({name, "_pc"}, dlv_log[idx].pc, exp_pc);
            check({name, "_instr"}, dlv_log[idx].instr, exp_instr);
            check({name, "_err"}, 32'(dlv_log[idx].err), 32'(exp_err));
        end
    endtask

    task automatic tick(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_logs();
        cmd_log.delete(); cmd_cyc.delete(); dlv_log.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.ifu_i_icb_cmd_ready = 1'b1;
        bus.ifu_i_instr_ready   = 1'b1;
        bus.ifu_i_redirect      = 1'b0;
        bus.ifu_i_redirect_pc   = 32'h0;
        bus.ifu_i_halt_req      = 1'b0;
        rsp_en   = 1'b1;
        err_addr = 32'h0000_0F00;
        tick(2);
        rst_n = 1'b1;
        rel_cyc = cyc + 1;
        clear_logs();
    endtask

    initial begin
        bus.ifu_i_icb_cmd_ready = 1'b0;
        bus.ifu_i_instr_ready   = 1'b0;
        bus.ifu_i_redirect      = 1'b0;
        bus.ifu_i_redirect_pc   = 32'h0;
        bus.ifu_i_halt_req      = 1'b0;
        bus.ifu_i_icb_rsp_valid = 1'b0;
        bus.ifu_i_icb_rsp_rdata = 32'h0;
        bus.ifu_i_icb_rsp_err   = 1'b0;

        // Basic streaming after reset release
        do_reset();
        tick(12);
        if (cmd_cyc.size() > 0) check("first_cmd_latency", 32'(cmd_cyc[0] - rel_cyc), 32'd1);
        chk_cmd("s1_cmd0", 0, 32'h0);
        chk_cmd("s1_cmd1", 1, 32'h4);
        chk_cmd("s1_cmd2", 2, 32'h8);
        chk_dlv("s1_i0", 0, 32'h0, 32'h0050_0093, 1'b0);
        chk_dlv("s1_i1", 1, 32'h4, 32'h0050_1093, 1'b0);

        // Decode stalled: credit limit stops fetch at two
        do_reset();
        bus.ifu_i_instr_ready = 1'b0;
        tick(10);
        check("s2_cmd_count", 32'(cmd_log.size()), 32'd2);
        chk_cmd("s2_cmd0", 0, 32'h0);
        chk_cmd("s2_cmd1", 1, 32'h4);
        check("s2_cmd_valid_blocked", 32'(bus.ifu_o_icb_cmd_valid), 32'd0);
        bus.ifu_i_instr_ready = 1'b1;
        tick(8);
        chk_dlv("s2_i0", 0, 32'h0, 32'h0050_0093, 1'b0);
        chk_dlv("s2_i1", 1, 32'h4, 32'h0050_1093, 1'b0);
        chk_cmd("s2_cmd2", 2, 32'h8);

        // Redirect with two requests in flight; first stale response lands in the redirect cycle
        do_reset();
        rsp_en = 1'b0;
        tick(6);
        check("s3_outstanding", 32'(cmd_log.size()), 32'd2);
        bus.ifu_i_redirect = 1'b1;
        bus.ifu_i_redirect_pc = 32'h0000_0103;
        rsp_en = 1'b1;
        clear_logs();
        tick(1);
        bus.ifu_i_redirect = 1'b0;
        tick(10);
        chk_cmd("s3_cmd0", 0, 32'h100);
        chk_dlv("s3_i0", 0, 32'h100, 32'h0054_0093, 1'b0);
        chk_dlv("s3_i1", 1, 32'h104, 32'h0054_1093, 1'b0);

        // Halt with one request outstanding
        do_reset();
        bus.ifu_i_icb_cmd_ready = 1'b0;
        rsp_en = 1'b0;
        tick(3);
        bus.ifu_i_icb_cmd_ready = 1'b1;
        tick(1);
        bus.ifu_i_icb_cmd_ready = 1'b0;
        bus.ifu_i_halt_req = 1'b1;
        tick(4);
        check("s4_ack_pending", 32'(bus.ifu_o_halt_ack), 32'd0);
        check("s4_one_cmd", 32'(cmd_log.size()), 32'd1);
        rsp_en = 1'b1;
        bus.ifu_i_icb_cmd_ready = 1'b1;
        tick(4);
        check("s4_ack", 32'(bus.ifu_o_halt_ack), 32'd1);
        check("s4_no_new_cmd", 32'(cmd_log.size()), 32'd1);
        chk_dlv("s4_i0", 0, 32'h0, 32'h0050_0093, 1'b0);
        bus.ifu_i_halt_req = 1'b0;
        tick(6);
        chk_cmd("s4_resume", 1, 32'h4);

        // Error flag carried with the faulting fetch only
        do_reset();
        err_addr = 32'h0000_0008;
        tick(14);
        chk_dlv("s5_i1", 1, 32'h4, 32'h0050_1093, 1'b0);
        chk_dlv("s5_i2", 2, 32'h8, 32'h0050_2093, 1'b1);
        chk_dlv("s5_i3", 3, 32'hC, 32'h0050_3093, 1'b0);

        // Address wrap at the top of memory
        do_reset();
        tick(3);
        bus.ifu_i_redirect = 1'b1;
        bus.ifu_i_redirect_pc = 32'hFFFF_FFFC;
        clear_logs();
        tick(1);
        bus.ifu_i_redirect = 1'b0;
        tick(10);
        chk_cmd("s6_cmd0", 0, 32'hFFFF_FFFC);
        chk_cmd("s6_cmd1", 1, 32'h0000_0000);
        chk_dlv("s6_i0", 0, 32'hFFFF_FFFC, 32'h004F_F093, 1'b0);
        chk_dlv("s6_i1", 1, 32'h0000_0000, 32'h0050_0093, 1'b0);

        tick(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
